reg_wb_ctrl: RTL and testbench
==============================

REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive cycles a queued long-latency result may be blocked before the pipeline is stalled.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pw_we  input  1  pipeline (MEM/WB) write request this cycle.
REQ-006 pw_wn  input  5  pipeline destination register.
REQ-007 pw_d  input  32  pipeline write data.
REQ-008 pw_stall  output  1  registered; upstream SHALL hold its write while high.
REQ-009 lu_valid  input  1  long-latency unit (mul/div) result valid.
REQ-010 lu_wn  input  5  long-latency destination register.
REQ-011 lu_d  input  32  long-latency result data.
REQ-012 lu_ready  output  1  result accepted when lu_valid && lu_ready.
REQ-013 iss_valid  input  1  issue of a long-latency op; marks iss_wn pending.
REQ-014 iss_wn  input  5  destination of issued long-latency op.
REQ-015 sb_ra, sb_rb  input  5 each  scoreboard query registers.
REQ-016 busy_a, busy_b  output  1 each  combinational pending[sb_ra], pending[sb_rb].
REQ-017 we, wn, d  output  1/5/32  registered register-file write port.

Function
REQ-018 Long-latency results SHALL enter a 2-entry FIFO; lu_ready = (count < 2), independent of a same-cycle pop.
REQ-019 Each cycle the write-port registers SHALL load exactly one source: pipeline if pw_we && pw_wn!=0 && !pw_stall; else FIFO head if non-empty (pop); else we<=0 (wn, d hold previous values).
REQ-020 Pipeline write latency SHALL be 1 cycle (request at edge t -> we at t+1); no FIFO bypass: FIFO result accepted at t appears on we no earlier than t+2.
REQ-021 Writes to register 0 SHALL never assert we: pipeline r0 requests ignored; lu results to r0 accepted (lu_ready rules apply) and discarded, not pushed.
REQ-022 Starvation counter SHALL increment each cycle FIFO is non-empty and no pop occurs, clear on pop or when FIFO empty, saturating at STARVE_LIMIT.
REQ-023 pw_stall SHALL be registered high the cycle after counter reaches STARVE_LIMIT and stay high until the FIFO head is popped; while high, pw_we is ignored.
REQ-024 Scoreboard: 32-bit pending vector; iss_valid && iss_wn!=0 sets bit; FIFO pop of register n clears bit n on the same edge we is loaded.
REQ-025 Simultaneous set and clear of the same bit SHALL leave it set; pending[0] SHALL always read 0.
REQ-026 Simultaneous push and pop with count==1 SHALL leave count==1 and preserve order (FIFO strictly in-order).
REQ-027 FIFO read/write pointers SHALL wrap modulo 2; count SHALL never exceed 2 or underflow.

Reset
REQ-028 On rst_n low, asynchronously: we=0, wn=0, d=0, pw_stall=0, FIFO empty (lu_ready=1), counter=0, pending all 0.
REQ-029 Reset mid-operation SHALL discard queued results and pending bits with no write emitted after release.
REQ-030 First write SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 pw_we=1, pw_wn=5, pw_d=0xDEADBEEF at edge t -> we=1, wn=5, d=0xDEADBEEF after t+1; pw_wn=0 -> we stays 0.
REQ-032 iss_valid, iss_wn=8; later lu_valid, lu_wn=8, lu_d=0x12345678, no pipeline traffic -> busy for r8 high until edge where we=1, wn=8 (2 cycles after accept), then low.
REQ-033 Two lu results queued, third lu_valid held -> lu_ready=0 until a pop; results written in acceptance order.
REQ-034 FIFO non-empty, pw_we=1 every cycle -> pw_stall rises after 4 blocked cycles, FIFO head written next, pw_stall falls; no pipeline write lost when upstream holds.
REQ-035 Same-edge iss_valid(r3) and pop of r3 result -> pending[3] remains 1.
REQ-036 rst_n pulsed low with 2 entries queued and pw_stall=1 -> all outputs 0, lu_ready=1, busy_a/busy_b=0, no write after release.

Source files
------------

// File: rtl/reg_wb_ctrl.sv
// Register-file write-back arbiter: merges pipeline writes with queued long-latency
// results through one write port, with a pending-destination scoreboard and anti-starvation stall.
module reg_wb_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pw_we,
  input  logic [4:0]  pw_wn,
  input  logic [31:0] pw_d,
  output logic        pw_stall,
  input  logic        lu_valid,
  input  logic [4:0]  lu_wn,
  input  logic [31:0] lu_d,
  output logic        lu_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wn,
  input  logic [4:0]  sb_ra,
  input  logic [4:0]  sb_rb,
  output logic        busy_a,
  output logic        busy_b,
  output logic        we,
  output logic [4:0]  wn,
  output logic [31:0] d
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [4:0]    fifo_wn [2];
  logic [31:0]   fifo_d  [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic [1:0]    count_next;
  logic [CW-1:0] starve_reg;
  logic [31:1]   pending_reg;
  logic [31:0]   pending_vec;

  logic          pw_accept;
  logic          push;
  logic          pop;
  logic [4:0]    head_wn;
  logic [31:0]   head_d;

  assign lu_ready  = (count_reg != 2'd2);
  // r0 results are handshaken normally but never occupy a FIFO slot
  assign push      = lu_valid && lu_ready && (lu_wn != 5'd0);
  assign pw_accept = pw_we && (pw_wn != 5'd0) && !pw_stall;
  assign pop       = !pw_accept && (count_reg != 2'd0);
  assign head_wn   = fifo_wn[rd_ptr_reg];
  assign head_d    = fifo_d[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wn[wr_ptr_reg] <= lu_wn;
      fifo_d[wr_ptr_reg]  <= lu_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // Starvation counter and the stall it raises once saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_reg <= '0;
      pw_stall   <= 1'b0;
    end else begin
      if (count_reg == 2'd0 || pop)
        starve_reg <= '0;
      else if (starve_reg != LIMIT)
        starve_reg <= starve_reg + 1'b1;
      pw_stall <= !pop && (pw_stall || (starve_reg == LIMIT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we <= 1'b0;
      wn <= 5'd0;
      d  <= 32'd0;
    end else if (pw_accept) begin
      we <= 1'b1;
      wn <= pw_wn;
      d  <= pw_d;
    end else if (pop) begin
      we <= 1'b1;
      wn <= head_wn;
      d  <= head_d;
    end else begin
      we <= 1'b0;
    end
  end

  // Issue-set wins over pop-clear so a re-issued destination stays busy
  for (genvar gi = 1; gi < 32; gi++) begin : g_pending
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        pending_reg[gi] <= 1'b0;
      else if (iss_valid && iss_wn == 5'(gi))
        pending_reg[gi] <= 1'b1;
      else if (pop && head_wn == 5'(gi))
        pending_reg[gi] <= 1'b0;
    end
  end

  assign pending_vec = {pending_reg, 1'b0};
  assign busy_a      = pending_vec[sb_ra];
  assign busy_b      = pending_vec[sb_rb];

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed self-checking bench for reg_wb_ctrl: pipeline path, FIFO path, scoreboard,
// back-pressure, starvation stall and reset behaviour.
module tb_reg_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pw_we;
  logic [4:0]  pw_wn;
  logic [31:0] pw_d;
  logic        pw_stall;
  logic        lu_valid;
  logic [4:0]  lu_wn;
  logic [31:0] lu_d;
  logic        lu_ready;
  logic        iss_valid;
  logic [4:0]  iss_wn;
  logic [4:0]  sb_ra;
  logic [4:0]  sb_rb;
  logic        busy_a;
  logic        busy_b;
  logic        we;
  logic [4:0]  wn;
  logic [31:0] d;

  int errors = 0;
  int checks = 0;

  reg_wb_ctrl #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pw_we(pw_we), .pw_wn(pw_wn), .pw_d(pw_d), .pw_stall(pw_stall),
    .lu_valid(lu_valid), .lu_wn(lu_wn), .lu_d(lu_d), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_wn(iss_wn),
    .sb_ra(sb_ra), .sb_rb(sb_rb), .busy_a(busy_a), .busy_b(busy_b),
    .we(we), .wn(wn), .d(d)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pw_we = 0; pw_wn = 0; pw_d = 0; lu_valid = 0; lu_wn = 0; lu_d = 0;
    iss_valid = 0; iss_wn = 0; sb_ra = 0; sb_rb = 0;
    tick(); tick();
    checks++; if (we !== 1'b0)     begin errors++; $display("FAIL reset_we got=%0b exp=0", we); end
    checks++; if (wn !== 5'd0)     begin errors++; $display("FAIL reset_wn got=%0d exp=0", wn); end
    checks++; if (d !== 32'd0)     begin errors++; $display("FAIL reset_d got=%h exp=0", d); end
    checks++; if (pw_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", pw_stall); end
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready got=%0b exp=1", lu_ready); end
    $display("reset: we=%0b wn=%0d d=%h stall=%0b lu_ready=%0b", we, wn, d, pw_stall, lu_ready);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_pipe_write();
    pw_we = 1; pw_wn = 5'd5; pw_d = 32'hDEADBEEF;
    tick();
    checks++; if (we !== 1'b1)          begin errors++; $display("FAIL pipe_we got=%0b exp=1", we); end
    checks++; if (wn !== 5'd5)          begin errors++; $display("FAIL pipe_wn got=%0d exp=5", wn); end
    checks++; if (d !== 32'hDEADBEEF)   begin errors++; $display("FAIL pipe_d got=%h exp=deadbeef", d); end
    $display("pipe write r5: we=%0b wn=%0d d=%h", we, wn, d);
    pw_wn = 5'd0; pw_d = 32'h1111_1111;
    tick();
    checks++; if (we !== 1'b0)          begin errors++; $display("FAIL pipe_r0_we got=%0b exp=0", we); end
    checks++; if (wn !== 5'd5 || d !== 32'hDEADBEEF)
      begin errors++; $display("FAIL pipe_r0_hold got=%0d/%h exp=5/deadbeef", wn, d); end
    $display("pipe write r0: we=%0b wn=%0d d=%h", we, wn, d);
    pw_we = 0;
  endtask

  task automatic test_lu_path();
    sb_ra = 5'd8;
    iss_valid = 1; iss_wn = 5'd8;
    tick();
    iss_valid = 0;
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL lu_busy_issue got=%0b exp=1", busy_a); end
    lu_valid = 1; lu_wn = 5'd8; lu_d = 32'h12345678;
    tick();
    lu_valid = 0;
    checks++; if (we !== 1'b0 || busy_a !== 1'b1)
      begin errors++; $display("FAIL lu_accept got=we%0b/busy%0b exp=we0/busy1", we, busy_a); end
    tick();
    checks++; if (we !== 1'b1 || wn !== 5'd8 || d !== 32'h12345678)
      begin errors++; $display("FAIL lu_write got=%0b/%0d/%h exp=1/8/12345678", we, wn, d); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL lu_busy_clear got=%0b exp=0", busy_a); end
    $display("lu write r8: we=%0b wn=%0d d=%h busy=%0b", we, wn, d, busy_a);
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL lu_idle got=%0b exp=0", we); end
  endtask

  task automatic test_fifo_full();
    pw_we = 1; pw_wn = 5'd1; pw_d = 32'h0000_0001;
    lu_valid = 1; lu_wn = 5'd10; lu_d = 32'hA0A0_A0A0;
    tick();
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got=%0b exp=1", lu_ready); end
    lu_wn = 5'd11; lu_d = 32'hB0B0_B0B0;
    tick();
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready2 got=%0b exp=0", lu_ready); end
    lu_wn = 5'd12; lu_d = 32'hC0C0_C0C0;
    tick();
    checks++; if (lu_ready !== 1'b0 || we !== 1'b1 || wn !== 5'd1)
      begin errors++; $display("FAIL full_hold got=rdy%0b/we%0b/wn%0d exp=rdy0/we1/wn1", lu_ready, we, wn); end
    pw_we = 0;
    tick();
    checks++; if (wn !== 5'd10 || d !== 32'hA0A0_A0A0 || lu_ready !== 1'b1)
      begin errors++; $display("FAIL full_pop1 got=%0d/%h/rdy%0b exp=10/a0a0a0a0/rdy1", wn, d, lu_ready); end
    $display("fifo pop: wn=%0d d=%h", wn, d);
    tick();
    lu_valid = 0;
    checks++; if (wn !== 5'd11 || d !== 32'hB0B0_B0B0)
      begin errors++; $display("FAIL full_pop2 got=%0d/%h exp=11/b0b0b0b0", wn, d); end
    $display("fifo pop: wn=%0d d=%h", wn, d);
    tick();
    checks++; if (we !== 1'b1 || wn !== 5'd12 || d !== 32'hC0C0_C0C0)
      begin errors++; $display("FAIL full_pop3 got=%0b/%0d/%h exp=1/12/c0c0c0c0", we, wn, d); end
    $display("fifo pop: wn=%0d d=%h", wn, d);
    tick();
    checks++; if (we !== 1'b0 || lu_ready !== 1'b1)
      begin errors++; $display("FAIL full_drain got=we%0b/rdy%0b exp=we0/rdy1", we, lu_ready); end
  endtask

  task automatic test_starve();
    pw_we = 1; pw_wn = 5'd2;
    lu_valid = 1; lu_wn = 5'd20; lu_d = 32'h0000_0055;
    for (int i = 0; i < 6; i++) begin
      pw_d = 32'd100 + 32'(i);
      tick();
      lu_valid = 0;
      checks++; if (pw_stall !== (i == 5) || we !== 1'b1 || wn !== 5'd2 || d !== 32'd100 + 32'(i))
        begin errors++; $display("FAIL starve_%0d got=stall%0b/%0d/%0d exp=stall%0b/2/%0d", i, pw_stall, wn, d, i == 5, 100 + i); end
      $display("starve cycle %0d: stall=%0b wn=%0d d=%0d", i, pw_stall, wn, d);
    end
    pw_d = 32'd106;
    tick();
    checks++; if (pw_stall !== 1'b0 || wn !== 5'd20 || d !== 32'h55)
      begin errors++; $display("FAIL starve_pop got=stall%0b/%0d/%h exp=stall0/20/55", pw_stall, wn, d); end
    tick();
    checks++; if (we !== 1'b1 || wn !== 5'd2 || d !== 32'd106)
      begin errors++; $display("FAIL starve_resume got=%0b/%0d/%0d exp=1/2/106", we, wn, d); end
    $display("starve resume: wn=%0d d=%0d", wn, d);
    pw_we = 0;
  endtask

  task automatic test_same_edge();
    sb_rb = 5'd3;
    iss_valid = 1; iss_wn = 5'd3;
    tick();
    iss_valid = 0;
    lu_valid = 1; lu_wn = 5'd3; lu_d = 32'h33;
    tick();
    lu_valid = 0;
    iss_valid = 1; iss_wn = 5'd3;
    tick();
    iss_valid = 0;
    checks++; if (we !== 1'b1 || wn !== 5'd3 || busy_b !== 1'b1)
      begin errors++; $display("FAIL same_edge got=we%0b/wn%0d/busy%0b exp=we1/wn3/busy1", we, wn, busy_b); end
    tick();
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL same_edge_hold got=%0b exp=1", busy_b); end
    $display("same-edge set/clear r3: busy=%0b", busy_b);
    // r0 result is accepted but never written; r0 issue never marks busy
    sb_ra = 5'd0;
    iss_valid = 1; iss_wn = 5'd0;
    lu_valid = 1; lu_wn = 5'd0; lu_d = 32'hFFFF_FFFF;
    tick();
    iss_valid = 0; lu_valid = 0;
    checks++; if (lu_ready !== 1'b1 || busy_a !== 1'b0)
      begin errors++; $display("FAIL r0_lu got=rdy%0b/busy%0b exp=rdy1/busy0", lu_ready, busy_a); end
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL r0_discard got=%0b exp=0", we); end
    $display("r0 result: we=%0b", we);
  endtask

  task automatic test_reset_mid();
    int waited;
    sb_ra = 5'd21; sb_rb = 5'd22;
    pw_we = 1; pw_wn = 5'd4; pw_d = 32'h44;
    iss_valid = 1; iss_wn = 5'd21; lu_valid = 1; lu_wn = 5'd21; lu_d = 32'h2121;
    tick();
    iss_wn = 5'd22; lu_wn = 5'd22; lu_d = 32'h2222;
    tick();
    iss_valid = 0; lu_valid = 0;
    waited = 0;
    while (pw_stall !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checks++; if (pw_stall !== 1'b1 || lu_ready !== 1'b0 || busy_a !== 1'b1 || busy_b !== 1'b1)
      begin errors++; $display("FAIL mid_setup got=stall%0b/rdy%0b/busy%0b%0b exp=stall1/rdy0/busy11", pw_stall, lu_ready, busy_a, busy_b); end
    pw_we = 0;
    rst_n = 1'b0;
    #1;
    checks++; if (we !== 1'b0 || wn !== 5'd0 || d !== 32'd0 || pw_stall !== 1'b0)
      begin errors++; $display("FAIL mid_reset_out got=%0b/%0d/%h/stall%0b exp=0/0/0/stall0", we, wn, d, pw_stall); end
    checks++; if (lu_ready !== 1'b1 || busy_a !== 1'b0 || busy_b !== 1'b0)
      begin errors++; $display("FAIL mid_reset_q got=rdy%0b/busy%0b%0b exp=rdy1/busy00", lu_ready, busy_a, busy_b); end
    $display("mid reset: we=%0b stall=%0b lu_ready=%0b", we, pw_stall, lu_ready);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_post_%0d got=%0b exp=0", i, we); end
    end
  endtask

  task automatic test_first_write();
    rst_n = 1'b0;
    tick();
    pw_we = 1; pw_wn = 5'd7; pw_d = 32'd77;
    #2 rst_n = 1'b1;
    tick();
    checks++; if (we !== 1'b1 || wn !== 5'd7 || d !== 32'd77)
      begin errors++; $display("FAIL first_write got=%0b/%0d/%0d exp=1/7/77", we, wn, d); end
    $display("first write after reset: we=%0b wn=%0d d=%0d", we, wn, d);
    pw_we = 0;
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_lu_path();
    test_fifo_full();
    test_starve();
    test_same_edge();
    test_reset_mid();
    test_first_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
